// File: rtl/add32_serial_pkg.sv
// add32_serial_pkg: shared FSM state encoding and default sizing for the serial adder.
package add32_serial_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;
  localparam int NSLICE = DEF_WIDTH / DEF_SLICE;
  localparam int CNT_W = $clog2(NSLICE);
endpackage

// File: rtl/add32_serial_slice.sv
// add4_slice: combinational SLICE-bit ripple adder exposing the carry into its top bit.
module add4_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [SLICE:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

// File: rtl/add32_serial.sv
// add32_serial: multi-cycle adder reusing one SLICE-bit slice, LSB first, with valid/ready on both sides.
// Define ADD32_SERIAL_OVF_EN to add the signed-overflow output ovf.
module add32_serial
  import add32_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef ADD32_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic cr, cout, last;
  logic [SLICE-1:0] s;
`ifdef ADD32_SERIAL_OVF_EN
  logic c_msb;
`else
  logic c_msb_unused;
`endif
  assign last = cnt == CW'(NS - 1);
  // operands shift down so the slice always sees the current nibble at bit 0
  add4_slice #(.SLICE(SLICE)) u_slice (
    .a(a_r[SLICE-1:0]),
    .b(b_r[SLICE-1:0]),
    .cin(cr),
    .s(s),
    .cout(cout),
`ifdef ADD32_SERIAL_OVF_EN
    .c_msb(c_msb)
`else
    .c_msb(c_msb_unused)
`endif
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN ? (last ? DONE : RUN) :
          (state == DONE && !out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      cr <= 1'b0;
      cnt <= '0;
      sum <= '0;
      carry <= 1'b0;
`ifdef ADD32_SERIAL_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r <= A;
      b_r <= B;
      cr <= c_in;
      cnt <= '0;
    end else if (state == RUN) begin
      a_r <= a_r >> SLICE;
      b_r <= b_r >> SLICE;
      cr <= cout;
      sum[cnt*SLICE +: SLICE] <= s;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        carry <= cout;
`ifdef ADD32_SERIAL_OVF_EN
        ovf <= c_msb ^ cout;
`endif
      end
    end
endmodule

// File: tb/tb_add32_serial.sv
// tb_add32_serial: directed vector table plus multi-cycle corner sequences for add32_serial.
module tb_add32_serial;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, c_in = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, carry;
  logic [31:0] sum;
`ifdef ADD32_SERIAL_OVF_EN
  logic ovf;
`endif
  int errors = 0, checks = 0;

  add32_serial dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry)
`ifdef ADD32_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic ci;
    logic [31:0] s;
    logic co;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // starts an operation and waits for out_valid; optionally scrambles inputs during RUN
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci, input bit scramble);
    int n;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    a = x; b = y; c_in = ci; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    if (scramble) begin a = ~x; b = x ^ y; c_in = ~ci; in_valid = 1; end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    in_valid = 0;
    chk("latency", 64'(n), 64'd8);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("out_valid_after_hs", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] e;
    int cyc, last_acc, done;
    v[0] = '{32'd5, 32'd7, 1'b0, 32'd12, 1'b0};
    v[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    v[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0};
    v[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    v[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    v[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    v[6] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1};

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 7; i++) begin
      run_op(v[i].a, v[i].b, v[i].ci, i == 2);
      chk($sformatf("sum_v%0d", i), 64'(sum), 64'(v[i].s));
      chk($sformatf("carry_v%0d", i), 64'(carry), 64'(v[i].co));
      handshake();
    end

    // reset in the middle of RUN after three slice edges
    run_op(32'h11111111, 32'h22222222, 1'b0, 0);
    handshake();
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01234567; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_carry", 64'(carry), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk) rst_n = 1;
    run_op(32'd5, 32'd7, 1'b0, 0);
    chk("postrst_sum", 64'(sum), 64'd12);
    chk("postrst_carry", 64'(carry), 64'd0);
    handshake();

    // backpressure in DONE, then a handshake cycle that also offers new operands
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; a = 32'h55555555; b = 32'hAAAAAAAA;
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", 64'(sum), 64'h00010000);
    end
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_not_accepted", 64'(in_ready), 64'd1);
    in_valid = 0;
    chk("hs_sum_hold", 64'(sum), 64'h00010000);

`ifdef ADD32_SERIAL_OVF_EN
    run_op(32'h7FFFFFFF, 32'd1, 1'b0, 0);
    chk("ovf1", 64'(ovf), 64'd1);
    chk("ovf1_carry", 64'(carry), 64'd0);
    chk("ovf1_sum", 64'(sum), 64'h80000000);
    handshake();
    run_op(32'h80000000, 32'h80000000, 1'b0, 0);
    chk("ovf2", 64'(ovf), 64'd1);
    chk("ovf2_carry", 64'(carry), 64'd1);
    chk("ovf2_sum", 64'(sum), 64'd0);
    handshake();
    run_op(32'd3, 32'd4, 1'b0, 0);
    chk("ovf3", 64'(ovf), 64'd0);
    chk("ovf3_sum", 64'(sum), 64'd7);
    handshake();
`endif

    // back-to-back with out_ready tied high against an arithmetic reference
    out_ready = 1;
    in_valid = 1;
    cyc = 0; last_acc = -1; done = 0;
    while (done < 1000 && cyc < 12000) begin
      @(negedge clk);
      if (out_valid) begin
        e = q.pop_front();
        chk("rand_sum", 64'(sum), 64'(e[31:0]));
        chk("rand_carry", 64'(carry), 64'(e[32]));
        done++;
      end
      a = $urandom; b = $urandom; c_in = 1'($urandom);
      if (in_ready && (q.size() + done) < 1000) begin
        q.push_back({1'b0, a} + {1'b0, b} + 33'(c_in));
        if (last_acc >= 0) chk("spacing", 64'(cyc - last_acc), 64'd10);
        last_acc = cyc;
      end
      cyc++;
    end
    chk("rand_done", 64'(done), 64'd1000);
    in_valid = 0; out_ready = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
